// File: rtl/des_key_ctrl.sv
// DES key-schedule controller: registers PC-1 of an accepted key, requests the 16 round
// keys from an external generator, buffers the responses and serves encrypt/decrypt reads.
module des_key_ctrl (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [63:0] key_in,
  input  logic        key_in_valid,
  output logic        key_in_ready,
  output logic [55:0] sub_key_out,
  output logic [3:0]  sub_key_idx_out,
  output logic        sub_key_valid_out,
  input  logic [47:0] round_key_in,
  input  logic        round_key_valid_in,
  input  logic        rd_en_in,
  input  logic [3:0]  rd_round_in,
  input  logic        decrypt_in,
  output logic [47:0] rd_key_out,
  output logic        rd_key_valid_out,
  output logic        keys_ready_out,
  output logic        err_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, READY} state_t;

  state_t      state, state_nxt;
  logic [3:0]  issue_cnt;
  logic [3:0]  resp_cnt;
  logic [2:0]  wd_cnt;
  logic [47:0] key_buf [16];
  logic        accept, in_sched, store, last_store, wd_expire, rd_ok;
  logic [3:0]  rd_idx;

  // key_in[63] is DES bit 1; parity bits (8,16,...,64) are dropped
  function automatic logic [55:0] pc1(input logic [63:0] k);
    return {k[7],  k[15], k[23], k[31], k[39], k[47], k[55], k[63],
            k[6],  k[14], k[22], k[30], k[38], k[46], k[54], k[62],
            k[5],  k[13], k[21], k[29], k[37], k[45], k[53], k[61],
            k[4],  k[12], k[20], k[28],
            k[1],  k[9],  k[17], k[25], k[33], k[41], k[49], k[57],
            k[2],  k[10], k[18], k[26], k[34], k[42], k[50], k[58],
            k[3],  k[11], k[19], k[27], k[35], k[43], k[51], k[59],
            k[36], k[44], k[52], k[60]};
  endfunction

  assign key_in_ready      = (state == IDLE) || (state == READY);
  assign sub_key_valid_out = (state == ISSUE);
  assign keys_ready_out    = (state == READY);
  assign sub_key_idx_out   = issue_cnt;

  assign accept     = key_in_valid && key_in_ready;
  assign in_sched   = (state == ISSUE) || (state == DRAIN);
  assign store      = in_sched && round_key_valid_in;
  assign last_store = store && (resp_cnt == 4'd15);
  // completion on the final watchdog cycle wins over expiry
  assign wd_expire  = (state == DRAIN) && (wd_cnt == 3'd7) && !last_store;
  assign rd_ok      = rd_en_in && (state == READY);
  assign rd_idx     = decrypt_in ? (4'd15 - rd_round_in) : rd_round_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE: begin
        if (last_store)              state_nxt = READY;
        else if (issue_cnt == 4'd15) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_store)     state_nxt = READY;
        else if (wd_expire) state_nxt = IDLE;
      end
      READY:   if (accept) state_nxt = ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sub_key_out      <= '0;
      issue_cnt        <= '0;
      resp_cnt         <= '0;
      wd_cnt           <= '0;
      rd_key_out       <= '0;
      rd_key_valid_out <= 1'b0;
      err_out          <= 1'b0;
    end else begin
      if (accept) begin
        sub_key_out <= pc1(key_in);
        issue_cnt   <= '0;
        resp_cnt    <= '0;
      end else begin
        if ((state == ISSUE) && (issue_cnt != 4'd15)) issue_cnt <= issue_cnt + 4'd1;
        if (store) resp_cnt <= resp_cnt + 4'd1;
      end
      wd_cnt           <= (state == DRAIN) ? wd_cnt + 3'd1 : '0;
      rd_key_valid_out <= rd_ok;
      if (rd_ok) rd_key_out <= key_buf[rd_idx];
      err_out          <= wd_expire || (rd_en_in && !rd_ok);
    end
  end

  // storage only; contents are meaningless until keys_ready_out
  always_ff @(posedge clk_in) begin
    if (store) key_buf[resp_cnt] <= round_key_in;
  end

endmodule

// File: tb/tb_des_key_ctrl.sv
// Bench for des_key_ctrl: behavioural round-key generator stub, read scoreboard,
// vector table for reads and directed sequences for the multi-cycle corner cases.
`timescale 1ns/1ps
module tb_des_key_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [63:0] key_in;
  logic        key_in_valid;
  logic        key_in_ready;
  logic [55:0] sub_key_out;
  logic [3:0]  sub_key_idx_out;
  logic        sub_key_valid_out;
  logic [47:0] round_key_in;
  logic        round_key_valid_in;
  logic        rd_en_in;
  logic [3:0]  rd_round_in;
  logic        decrypt_in;
  logic [47:0] rd_key_out;
  logic        rd_key_valid_out;
  logic        keys_ready_out;
  logic        err_out;

  always #5 clk_in = ~clk_in;

  des_key_ctrl dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .key_in            (key_in),
    .key_in_valid      (key_in_valid),
    .key_in_ready      (key_in_ready),
    .sub_key_out       (sub_key_out),
    .sub_key_idx_out   (sub_key_idx_out),
    .sub_key_valid_out (sub_key_valid_out),
    .round_key_in      (round_key_in),
    .round_key_valid_in(round_key_valid_in),
    .rd_en_in          (rd_en_in),
    .rd_round_in       (rd_round_in),
    .decrypt_in        (decrypt_in),
    .rd_key_out        (rd_key_out),
    .rd_key_valid_out  (rd_key_valid_out),
    .keys_ready_out    (keys_ready_out),
    .err_out           (err_out)
  );

  localparam int PC1_T [56] = '{57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
                                10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
  localparam int PC2_T [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,
                                23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                                41,52,31,37,47,55,30,40,51,45,33,48,
                                44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  function automatic logic [55:0] pc1_model(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1_T[i])];
    return r;
  endfunction

  function automatic logic [47:0] gen_rk(input logic [55:0] cd0, input logic [3:0] idx);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] rk;
    int          sh;
    c  = cd0[55:28];
    d  = cd0[27:0];
    sh = 0;
    rk = '0;
    for (int i = 0; i <= int'(idx); i++) sh += SHIFTS[i];
    for (int j = 0; j < sh; j++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) rk[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
    return rk;
  endfunction

  // one-cycle generator stub, with optional dropped response and stray injection
  logic        gen_valid   = 1'b0;
  logic [47:0] gen_key     = '0;
  logic        drop_en     = 1'b0;
  logic        stray_valid = 1'b0;
  logic [47:0] stray_data  = '0;

  always @(posedge clk_in) begin
    gen_valid <= rst_n_in && sub_key_valid_out && !(drop_en && (sub_key_idx_out == 4'd9));
    gen_key   <= gen_rk(sub_key_out, sub_key_idx_out);
  end

  assign round_key_valid_in = gen_valid | stray_valid;
  assign round_key_in       = stray_valid ? stray_data : gen_key;

  int          n_vec = 0;
  int          n_err = 0;
  logic [47:0] exp_q[$];
  logic [47:0] last_rd_exp = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_in) begin : rd_monitor
    logic [47:0] e;
    if (rst_n_in && rd_key_valid_out) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 64'(rd_key_valid_out), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rd_key", 64'(rd_key_out), 64'(e));
        last_rd_exp = e;
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_key_in_ready", 64'(key_in_ready), 64'd1);
    check("rst_sub_key", 64'(sub_key_out), 64'd0);
    check("rst_sub_idx", 64'(sub_key_idx_out), 64'd0);
    check("rst_sub_valid", 64'(sub_key_valid_out), 64'd0);
    check("rst_rd_key", 64'(rd_key_out), 64'd0);
    check("rst_rd_valid", 64'(rd_key_valid_out), 64'd0);
    check("rst_keys_ready", 64'(keys_ready_out), 64'd0);
    check("rst_err", 64'(err_out), 64'd0);
  endtask

  task automatic accept_key(input logic [63:0] k, input bit hold, input bit with_read,
                            input logic [47:0] old_exp);
    int budget;
    budget = 0;
    while (!key_in_ready && budget < 50) begin
      tick();
      budget++;
    end
    check("key_in_ready_wait", 64'(key_in_ready), 64'd1);
    key_in       = k;
    key_in_valid = 1'b1;
    if (with_read) begin
      rd_en_in    = 1'b1;
      rd_round_in = 4'd0;
      decrypt_in  = 1'b0;
      exp_q.push_back(old_exp);
    end
    tick();
    if (!hold) key_in_valid = 1'b0;
    rd_en_in = 1'b0;
    check("keys_ready_on_accept", 64'(keys_ready_out), 64'd0);
  endtask

  // entered #1 after the accept edge; leaves #1 after accept edge + 17
  task automatic run_issue(input logic [55:0] exp_sub, input int rd_at, input bit expect_done);
    for (int i = 0; i < 16; i++) begin
      check("issue_idx", 64'({sub_key_valid_out, sub_key_idx_out}), 64'({1'b1, 4'(i)}));
      check("key_in_ready_issue", 64'(key_in_ready), 64'd0);
      if (i == 0 || i == 15) check("sub_key_out", 64'(sub_key_out), 64'(exp_sub));
      if (rd_at >= 0 && i == rd_at + 1) begin
        check("rd_issue_err", 64'(err_out), 64'd1);
        check("rd_issue_valid", 64'(rd_key_valid_out), 64'd0);
        check("rd_issue_hold", 64'(rd_key_out), 64'(last_rd_exp));
      end
      rd_en_in = (i == rd_at);
      if (i == 10) key_in_valid = 1'b0;
      tick();
    end
    rd_en_in = 1'b0;
    check("drain_sub_valid", 64'(sub_key_valid_out), 64'd0);
    check("keys_ready_edge16", 64'(keys_ready_out), 64'd0);
    tick();
    check("keys_ready_edge17", 64'(keys_ready_out), 64'(expect_done));
  endtask

  task automatic do_read(input logic dec, input logic [3:0] rnd, input logic [47:0] exp);
    rd_en_in    = 1'b1;
    rd_round_in = rnd;
    decrypt_in  = dec;
    exp_q.push_back(exp);
    tick();
    rd_en_in = 1'b0;
  endtask

  typedef struct {
    logic        dec;
    logic [3:0]  rnd;
    logic [47:0] exp;
  } vec_t;

  localparam logic [63:0] K0   = 64'h133457799BBCDFF1;
  localparam logic [55:0] SUB0 = 56'hF0CCAAF556678F;
  localparam logic [47:0] RK1  = 48'h1B02EFFC7072;
  localparam logic [47:0] RK16 = 48'hCB3D8B0E17F5;
  localparam logic [63:0] K1   = 64'h0E329232EA6D0D73;

  vec_t        vecs [8];
  logic [55:0] sub1;

  initial begin
    rst_n_in     = 1'b0;
    key_in       = '0;
    key_in_valid = 1'b0;
    rd_en_in     = 1'b0;
    rd_round_in  = '0;
    decrypt_in   = 1'b0;
    sub1         = pc1_model(K1);

    vecs[0] = '{1'b0, 4'd0,  RK1};
    vecs[1] = '{1'b0, 4'd15, RK16};
    vecs[2] = '{1'b1, 4'd0,  RK16};
    vecs[3] = '{1'b1, 4'd15, RK1};
    vecs[4] = '{1'b0, 4'd1,  gen_rk(SUB0, 4'd1)};
    vecs[5] = '{1'b0, 4'd7,  gen_rk(SUB0, 4'd7)};
    vecs[6] = '{1'b1, 4'd8,  gen_rk(SUB0, 4'd7)};
    vecs[7] = '{1'b1, 4'd14, gen_rk(SUB0, 4'd1)};

    @(posedge clk_in);
    #1;
    check_reset_outputs();
    tick();
    rst_n_in = 1'b1;
    tick();

    // reference key, full schedule, table of reads
    accept_key(K0, 1'b0, 1'b0, '0);
    run_issue(SUB0, -1, 1'b1);
    foreach (vecs[i]) do_read(vecs[i].dec, vecs[i].rnd, vecs[i].exp);
    tick();
    tick();
    check("sb_empty_table", 64'(exp_q.size()), 64'd0);

    // stray generator response in READY must not disturb the buffer
    stray_valid = 1'b1;
    stray_data  = '1;
    tick();
    stray_valid = 1'b0;
    check("stray_keys_ready", 64'(keys_ready_out), 64'd1);
    do_read(1'b0, 4'd0, RK1);
    tick();

    // key held through ISSUE and a read attempted mid-schedule
    accept_key(K1, 1'b1, 1'b0, '0);
    run_issue(sub1, 3, 1'b1);
    do_read(1'b1, 4'd4, gen_rk(sub1, 4'd11));
    tick();

    // dropped response 9: watchdog expiry 8 cycles after DRAIN entry
    drop_en = 1'b1;
    accept_key(K0, 1'b0, 1'b0, '0);
    run_issue(SUB0, -1, 1'b0);
    drop_en = 1'b0;
    repeat (6) tick();
    check("wd_err_early", 64'(err_out), 64'd0);
    tick();
    check("wd_err_pulse", 64'(err_out), 64'd1);
    check("wd_key_in_ready", 64'(key_in_ready), 64'd1);
    check("wd_keys_ready", 64'(keys_ready_out), 64'd0);
    tick();
    check("wd_err_end", 64'(err_out), 64'd0);

    // reset asserted at issue index 7
    accept_key(K1, 1'b0, 1'b0, '0);
    repeat (7) tick();
    check("pre_rst_idx", 64'({sub_key_valid_out, sub_key_idx_out}), 64'h17);
    rst_n_in = 1'b0;
    #1;
    check_reset_outputs();
    tick();
    check("in_rst_sub_valid", 64'(sub_key_valid_out), 64'd0);
    rst_n_in    = 1'b1;
    last_rd_exp = '0;
    tick();
    check("post_rst_sub_valid", 64'(sub_key_valid_out), 64'd0);
    accept_key(K0, 1'b0, 1'b0, '0);
    run_issue(SUB0, -1, 1'b1);
    do_read(1'b1, 4'd0, RK16);
    do_read(1'b0, 4'd15, RK16);
    tick();

    // new key accepted in READY together with a read of the old schedule
    accept_key(K1, 1'b0, 1'b1, RK1);
    run_issue(sub1, -1, 1'b1);
    do_read(1'b0, 4'd0, gen_rk(sub1, 4'd0));
    tick();
    tick();
    check("sb_empty_end", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/des_key_ctrl.md
DES_KEY_CTRL -- requirements
Module: des_key_ctrl

Interface
REQ-001 SHALL have clk_in, input, 1, clock; all state changes on its rising edge.
REQ-002 SHALL have rst_n_in, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have key_in, input, 64, DES key; bit 63 = DES bit 1; parity bits ignored.
REQ-004 SHALL have key_in_valid, input, 1, key offer; and key_in_ready, output, 1, key acceptance.
REQ-005 SHALL have sub_key_out, output, 56, PC-1(key_in) = C0||D0; PC-1 bit 1 maps to sub_key_out[55].
REQ-006 SHALL have sub_key_idx_out, output, 4, round index to the round-key generator.
REQ-007 SHALL have sub_key_valid_out, output, 1, qualifies sub_key_out/sub_key_idx_out.
REQ-008 SHALL have round_key_in, input, 48, generator result; and round_key_valid_in, input, 1, its qualifier.
REQ-009 SHALL have rd_en_in (1), rd_round_in (4) and decrypt_in (1), all inputs, forming the round-key read request.
REQ-010 SHALL have rd_key_out, output, 48, read data; and rd_key_valid_out, output, 1, read data qualifier.
REQ-011 SHALL have keys_ready_out, output, 1, all 16 keys stored; and err_out, output, 1, one-cycle error pulse.

Function
REQ-012 SHALL implement states IDLE, ISSUE, DRAIN and READY.
REQ-013 key_in_ready SHALL be 1 in IDLE and READY, and 0 in ISSUE and DRAIN.
REQ-014 Acceptance (key_in_valid & key_in_ready) SHALL register PC-1(key_in), clear the issue counter, response counter and keys_ready_out, and enter ISSUE.
REQ-015 ISSUE SHALL drive sub_key_valid_out=1 with sub_key_idx_out=0,1,...,15 on 16 consecutive cycles, holding sub_key_out constant.
REQ-016 After index 15 is issued, the state SHALL move to DRAIN; sub_key_valid_out SHALL be 0 outside ISSUE.
REQ-017 In ISSUE and DRAIN, each round_key_valid_in SHALL write round_key_in to a 16x48 buffer at the response counter, then increment the counter.
REQ-018 round_key_valid_in outside ISSUE and DRAIN SHALL be ignored: no write and no counter change.
REQ-019 The clock edge storing the 16th key SHALL set keys_ready_out=1 and enter READY.
REQ-020 With a 1-cycle generator, keys_ready_out SHALL be high 17 cycles after the accept edge.
REQ-021 A DRAIN watchdog SHALL allow 8 cycles; on expiry it SHALL pulse err_out for 1 cycle and return to IDLE with keys_ready_out=0.
REQ-022 A new key accepted in READY SHALL drop keys_ready_out on the accept edge and restart ISSUE; old buffer contents become invalid.
REQ-023 Read: a rd_en_in sampled in READY SHALL return the entry in the next cycle on rd_key_out, with rd_key_valid_out=1 for 1 cycle.
REQ-024 The entry read SHALL be rd_round_in when decrypt_in=0, and 15-rd_round_in (4-bit) when decrypt_in=1.
REQ-025 rd_en_in outside READY SHALL leave rd_key_valid_out=0 and rd_key_out unchanged, and SHALL pulse err_out the next cycle.
REQ-026 If rd_en_in and a key acceptance occur on the same edge, the read SHALL be serviced from the old contents and the new schedule SHALL start.
REQ-027 rd_key_out SHALL hold its last value when rd_key_valid_out=0.

Reset
REQ-028 Reset assertion SHALL force IDLE, clear all counters and the watchdog, and mid-operation SHALL abort any schedule with no further sub_key_valid_out.
REQ-029 During reset, outputs SHALL be: key_in_ready=1, sub_key_out=0, sub_key_idx_out=0, sub_key_valid_out=0, rd_key_out=0, rd_key_valid_out=0, keys_ready_out=0, err_out=0; buffer contents are not reset.

Verification
REQ-030 Key 133457799BBCDFF1 with the generator attached -> sub_key_out=F0CCAAF556678F; after keys_ready_out, encrypt reads give round 0=1B02EFFC7072 and round 15=CB3D8B0E17F5.
REQ-031 Same key, decrypt_in=1, rd_round_in=0 -> rd_key_out=CB3D8B0E17F5 one cycle later with rd_key_valid_out=1.
REQ-032 Generator stub drops response 9 -> no keys_ready_out; err_out pulses 8 cycles after DRAIN entry; state returns to IDLE with key_in_ready=1.
REQ-033 key_in_valid held during ISSUE -> key_in_ready=0 and no re-accept; rd_en_in during ISSUE -> err_out pulse and rd_key_valid_out=0.
REQ-034 rst_n_in asserted at issue index 7 -> all outputs at reset values immediately; after release, a full 16-key schedule completes normally.
REQ-035 New key offered in READY together with rd_en_in -> old key returned; keys_ready_out drops on the accept edge, then reasserts 17 cycles later.
